// File: rtl/sec1_point_serializer_if.sv
// Point-capture and byte-stream signals of sec1_point_serializer.
// slave = the serializer itself, master = the producer/sink side driving it.
interface sec1_point_serializer_if #(
    parameter int COORD_W = 256
);
    logic               pt_valid;
    logic               pt_ready;
    logic [COORD_W-1:0] Xin;
    logic [COORD_W-1:0] Yin;
    logic               inf_in;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               tx_last;

    modport master (
        output pt_valid, Xin, Yin, inf_in, tx_ready,
        input  pt_ready, tx_data, tx_valid, tx_last
    );

    modport slave (
        input  pt_valid, Xin, Yin, inf_in, tx_ready,
        output pt_ready, tx_data, tx_valid, tx_last
    );
endinterface

// File: rtl/sec1_point_serializer.sv
// SEC1 encoder for an affine secp256k1 point: 0x00 for infinity, else prefix + X (+ Y).
// Define SEC1_UNCOMPRESSED_EN for 0x04 + X + Y frames; default is compressed 0x02/0x03 + X.
module sec1_point_serializer #(
    parameter int COORD_W = 256,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    sec1_point_serializer_if.slave   bus,
    output logic                     busy,
    output logic [CNT_W-1:0]         frames_sent
);
    localparam int         NBYTES    = COORD_W / 8;
    localparam logic [6:0] LAST_BEAT = 7'(NBYTES - 1);

`ifdef SEC1_UNCOMPRESSED_EN
    localparam bit UNCOMP = 1'b1;
    typedef enum logic [1:0] {IDLE, PREFIX, XBYTES, YBYTES} state_t;
    logic [COORD_W-1:0] y_sr;
`else
    localparam bit UNCOMP = 1'b0;
    typedef enum logic [1:0] {IDLE, PREFIX, XBYTES} state_t;
`endif

    state_t             state;
    logic [COORD_W-1:0] x_sr;
    logic [6:0]         beat_cnt;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_last;
    logic               accept;

    assign accept       = tx_valid && bus.tx_ready;
    assign bus.pt_ready = (state == IDLE);
    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;
    assign bus.tx_last  = tx_last;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            x_sr        <= '0;
`ifdef SEC1_UNCOMPRESSED_EN
            y_sr        <= '0;
`endif
            beat_cnt    <= '0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            tx_last     <= 1'b0;
            frames_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.pt_valid) begin
                        x_sr     <= bus.Xin;
`ifdef SEC1_UNCOMPRESSED_EN
                        y_sr     <= bus.Yin;
`endif
                        beat_cnt <= '0;
                        tx_valid <= 1'b1;
                        tx_last  <= bus.inf_in;
                        if (bus.inf_in)
                            tx_data <= 8'h00;
                        else if (UNCOMP)
                            tx_data <= 8'h04;
                        else
                            tx_data <= {7'b0000001, bus.Yin[0]};
                        state    <= PREFIX;
                    end
                end

                // tx_last is only ever set on the prefix beat for the infinity frame
                PREFIX: begin
                    if (accept) begin
                        if (tx_last) begin
                            state       <= IDLE;
                            tx_valid    <= 1'b0;
                            tx_last     <= 1'b0;
                            frames_sent <= frames_sent + CNT_W'(1);
                        end else begin
                            tx_data  <= x_sr[COORD_W-1 -: 8];
                            x_sr     <= x_sr << 8;
                            beat_cnt <= '0;
                            tx_last  <= !UNCOMP && (LAST_BEAT == 7'd0);
                            state    <= XBYTES;
                        end
                    end
                end

                XBYTES: begin
                    if (accept) begin
                        if (beat_cnt == LAST_BEAT) begin
`ifdef SEC1_UNCOMPRESSED_EN
                            tx_data  <= y_sr[COORD_W-1 -: 8];
                            y_sr     <= y_sr << 8;
                            beat_cnt <= '0;
                            tx_last  <= (LAST_BEAT == 7'd0);
                            state    <= YBYTES;
`else
                            state       <= IDLE;
                            tx_valid    <= 1'b0;
                            tx_last     <= 1'b0;
                            frames_sent <= frames_sent + CNT_W'(1);
`endif
                        end else begin
                            tx_data  <= x_sr[COORD_W-1 -: 8];
                            x_sr     <= x_sr << 8;
                            beat_cnt <= beat_cnt + 7'd1;
                            tx_last  <= !UNCOMP && ((beat_cnt + 7'd1) == LAST_BEAT);
                        end
                    end
                end

`ifdef SEC1_UNCOMPRESSED_EN
                YBYTES: begin
                    if (accept) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state       <= IDLE;
                            tx_valid    <= 1'b0;
                            tx_last     <= 1'b0;
                            frames_sent <= frames_sent + CNT_W'(1);
                        end else begin
                            tx_data  <= y_sr[COORD_W-1 -: 8];
                            y_sr     <= y_sr << 8;
                            beat_cnt <= beat_cnt + 7'd1;
                            tx_last  <= ((beat_cnt + 7'd1) == LAST_BEAT);
                        end
                    end
                end
`endif

                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    tx_last  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sec1_point_serializer.sv
// Bench for sec1_point_serializer: expected frames come from a byte-list model of the SEC1 encoding.
module tb_sec1_point_serializer;
    localparam int COORD_W = 256;
    localparam int CNT_W   = 16;
    localparam int NBYTES  = COORD_W / 8;
`ifdef SEC1_UNCOMPRESSED_EN
    localparam bit UNC = 1'b1;
`else
    localparam bit UNC = 1'b0;
`endif
    localparam int FLEN = UNC ? (1 + 2 * NBYTES) : (1 + NBYTES);

    localparam logic [COORD_W-1:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [COORD_W-1:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    // edge bytes follow the odd-Y reference vector; the middle is arbitrary as coordinates are not range-checked
    localparam logic [COORD_W-1:0] PX = 256'h882F2F95_00112233_44556677_8899AABB_CCDDEEFF_01234567_89ABCDEF_36BAD700;
    localparam logic [COORD_W-1:0] PY = 256'hE57A34CF_10203040_50607080_90A0B0C0_D0E0F001_02030405_06070809_6FA622B5;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic [CNT_W-1:0] frames_sent;

    always #5 clk = ~clk;

    sec1_point_serializer_if #(.COORD_W(COORD_W)) bus ();

    sec1_point_serializer #(.COORD_W(COORD_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    int errors = 0;
    int checks = 0;
    logic [CNT_W-1:0] exp_frames;

    logic [7:0] exp_data[$];
    bit         exp_last[$];
    logic [7:0] got_data[$];
    bit         got_last[$];
    int vcycles, tcycles, stall_bad;
    bit timed_out, aborted, inj_ready_seen;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [COORD_W-1:0] rand_coord();
        logic [COORD_W-1:0] v = '0;
        for (int i = 0; i < COORD_W / 32; i++) v = (v << 32) | COORD_W'($urandom());
        return v;
    endfunction

    // SEC1 byte list: 0x00 | prefix, X big-endian [, Y big-endian]
    function automatic void build_expected(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y, input bit inf);
        exp_data.delete();
        exp_last.delete();
        if (inf) begin
            exp_data.push_back(8'h00);
        end else begin
            if (UNC) exp_data.push_back(8'h04);
            else     exp_data.push_back(y[0] ? 8'h03 : 8'h02);
            for (int i = 0; i < NBYTES; i++) exp_data.push_back(x[COORD_W-1-8*i -: 8]);
            if (UNC)
                for (int i = 0; i < NBYTES; i++) exp_data.push_back(y[COORD_W-1-8*i -: 8]);
        end
        for (int i = 0; i < exp_data.size(); i++) exp_last.push_back(i == exp_data.size() - 1);
    endfunction

    function automatic int frame_diffs();
        int n = (got_data.size() > exp_data.size()) ? got_data.size() - exp_data.size()
                                                    : exp_data.size() - got_data.size();
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) n++;
        return n;
    endfunction

    task automatic send_point(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y, input bit inf);
        bus.Xin = x;
        bus.Yin = y;
        bus.inf_in = inf;
        bus.pt_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.pt_valid = 1'b0;
    endtask

    // mode 0: ready high, 1: ready toggles per valid cycle starting low, 2: random ready
    task automatic collect(input int mode, input int inj_beat, input int rst_beat);
        bit tgl = 1'b0, prev_stall = 1'b0, done = 1'b0;
        logic [7:0] pd = 8'h00;
        bit pl = 1'b0;
        int acc = 0;
        got_data.delete();
        got_last.delete();
        vcycles = 0; tcycles = 0; stall_bad = 0;
        timed_out = 1'b1; aborted = 1'b0; inj_ready_seen = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            bus.pt_valid = 1'b0;
            if (acc == rst_beat) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                timed_out = 1'b0;
                break;
            end
            case (mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = tgl;
                default: bus.tx_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (bus.tx_valid && acc == inj_beat) begin
                bus.Xin = rand_coord();
                bus.Yin = rand_coord();
                bus.inf_in = 1'b0;
                bus.pt_valid = 1'b1;
                inj_ready_seen = bus.pt_ready;
            end
            tcycles++;
            if (bus.tx_valid) begin
                vcycles++;
                if (prev_stall && (bus.tx_data !== pd || bus.tx_last !== pl)) stall_bad++;
                pd = bus.tx_data;
                pl = bus.tx_last;
                prev_stall = !bus.tx_ready;
                tgl = !tgl;
                if (bus.tx_ready) begin
                    got_data.push_back(bus.tx_data);
                    got_last.push_back(bus.tx_last);
                    acc++;
                    if (bus.tx_last) done = 1'b1;
                end
            end else begin
                prev_stall = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.pt_valid = 1'b0;
        bus.tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        bus.pt_valid = 1'b0; bus.tx_ready = 1'b1; bus.inf_in = 1'b0;
        bus.Xin = '0; bus.Yin = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_frames = '0;
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
        checks++; if (bus.tx_last !== 1'b0) begin errors++; $display("FAIL reset_tx_last got=%b exp=0", bus.tx_last); end
        checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL reset_frames got=%0d exp=%0d", frames_sent, exp_frames); end
        checks++; if (bus.pt_ready !== 1'b1) begin errors++; $display("FAIL reset_pt_ready got=%b exp=1", bus.pt_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_generator();
        int d;
        build_expected(GX, GY, 1'b0);
        send_point(GX, GY, 1'b0);
        collect(0, -1, -1);
        exp_frames++;
        d = frame_diffs();
        checks++; if (timed_out) begin errors++; $display("FAIL gen_timeout got=timeout exp=frame"); end
        checks++; if (d !== 0) begin errors++; $display("FAIL gen_frame diffs=%0d exp=0 (len got=%0d exp=%0d)", d, got_data.size(), FLEN); end
        checks++; if (got_data[0] !== (UNC ? 8'h04 : 8'h02)) begin errors++; $display("FAIL gen_prefix got=%h exp=%h", got_data[0], UNC ? 8'h04 : 8'h02); end
        checks++; if (got_data[1] !== 8'h79) begin errors++; $display("FAIL gen_x_msb got=%h exp=79", got_data[1]); end
        checks++; if (got_data[got_data.size()-1] !== (UNC ? 8'hb8 : 8'h98) || got_last[got_last.size()-1] !== 1'b1) begin
            errors++; $display("FAIL gen_last_byte got=%h/%b exp=%h/1", got_data[got_data.size()-1], got_last[got_last.size()-1], UNC ? 8'hb8 : 8'h98);
        end
        checks++; if (tcycles !== FLEN) begin errors++; $display("FAIL gen_cycles got=%0d exp=%0d", tcycles, FLEN); end
        checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL gen_frames got=%0d exp=%0d", frames_sent, exp_frames); end
        checks++; if (busy !== 1'b0 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL gen_idle busy=%b tx_valid=%b exp=0/0", busy, bus.tx_valid); end
    endtask

    task automatic test_odd_y();
        int d;
        build_expected(PX, PY, 1'b0);
        send_point(PX, PY, 1'b0);
        collect(2, -1, -1);
        exp_frames++;
        d = frame_diffs();
        checks++; if (timed_out || d !== 0) begin errors++; $display("FAIL oddy_frame diffs=%0d timeout=%b exp=0/0", d, timed_out); end
        checks++; if (got_data[0] !== (UNC ? 8'h04 : 8'h03)) begin errors++; $display("FAIL oddy_prefix got=%h exp=%h", got_data[0], UNC ? 8'h04 : 8'h03); end
        checks++; if (got_data[got_data.size()-1] !== (UNC ? 8'hb5 : 8'h00)) begin errors++; $display("FAIL oddy_last got=%h exp=%h", got_data[got_data.size()-1], UNC ? 8'hb5 : 8'h00); end
        checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL oddy_frames got=%0d exp=%0d", frames_sent, exp_frames); end
    endtask

    task automatic test_infinity();
        send_point(rand_coord(), rand_coord(), 1'b1);
        collect(0, -1, -1);
        exp_frames++;
        checks++; if (got_data.size() !== 1) begin errors++; $display("FAIL inf_len got=%0d exp=1", got_data.size()); end
        checks++; if (got_data[0] !== 8'h00 || got_last[0] !== 1'b1) begin errors++; $display("FAIL inf_byte got=%h/%b exp=00/1", got_data[0], got_last[0]); end
        checks++; if (tcycles !== 1) begin errors++; $display("FAIL inf_cycles got=%0d exp=1", tcycles); end
        checks++; if (frames_sent !== exp_frames || busy !== 1'b0) begin errors++; $display("FAIL inf_frames got=%0d busy=%b exp=%0d/0", frames_sent, busy, exp_frames); end
    endtask

    task automatic test_stall();
        int d;
        build_expected(GX, GY, 1'b0);
        send_point(GX, GY, 1'b0);
        collect(1, -1, -1);
        exp_frames++;
        d = frame_diffs();
        checks++; if (timed_out || d !== 0) begin errors++; $display("FAIL stall_frame diffs=%0d timeout=%b exp=0/0", d, timed_out); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold got=%0d changes exp=0", stall_bad); end
        checks++; if (vcycles !== 2 * FLEN) begin errors++; $display("FAIL stall_valid_cycles got=%0d exp=%0d", vcycles, 2 * FLEN); end
        checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL stall_frames got=%0d exp=%0d", frames_sent, exp_frames); end
    endtask

    task automatic test_busy_ignore();
        int d, extra = 0;
        build_expected(GX, GY, 1'b0);
        send_point(GX, GY, 1'b0);
        collect(0, 5, -1);
        exp_frames++;
        d = frame_diffs();
        repeat (6) begin
            if (bus.tx_valid) extra++;
            @(negedge clk);
        end
        checks++; if (inj_ready_seen !== 1'b0) begin errors++; $display("FAIL busy_pt_ready got=%b exp=0", inj_ready_seen); end
        checks++; if (d !== 0) begin errors++; $display("FAIL busy_frame diffs=%0d exp=0", d); end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_late_capture got=%0d valid cycles exp=0", extra); end
        checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL busy_frames got=%0d exp=%0d", frames_sent, exp_frames); end
    endtask

    task automatic test_final_collision();
        int d, extra = 0;
        logic [COORD_W-1:0] x = rand_coord(), y = rand_coord();
        build_expected(x, y, 1'b0);
        send_point(x, y, 1'b0);
        collect(0, FLEN - 1, -1);
        exp_frames++;
        d = frame_diffs();
        checks++; if (inj_ready_seen !== 1'b0) begin errors++; $display("FAIL coll_pt_ready got=%b exp=0", inj_ready_seen); end
        checks++; if (bus.pt_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL coll_bubble pt_ready=%b tx_valid=%b exp=1/0", bus.pt_ready, bus.tx_valid); end
        repeat (5) begin
            if (bus.tx_valid) extra++;
            @(negedge clk);
        end
        checks++; if (d !== 0 || extra !== 0) begin errors++; $display("FAIL coll_frame diffs=%0d extra=%0d exp=0/0", d, extra); end
        checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL coll_frames got=%0d exp=%0d", frames_sent, exp_frames); end
    endtask

    task automatic test_midframe_reset();
        int d;
        logic [COORD_W-1:0] x = rand_coord(), y = rand_coord();
        send_point(GX, GY, 1'b0);
        collect(0, 5, 10);
        exp_frames = '0;
        checks++; if (!aborted || got_data.size() !== 10) begin errors++; $display("FAIL rst_abort aborted=%b beats=%0d exp=1/10", aborted, got_data.size()); end
        checks++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_idle tx_valid=%b busy=%b exp=0/0", bus.tx_valid, busy); end
        checks++; if (frames_sent !== exp_frames || bus.pt_ready !== 1'b1) begin errors++; $display("FAIL rst_state frames=%0d pt_ready=%b exp=0/1", frames_sent, bus.pt_ready); end
        build_expected(x, y, 1'b0);
        send_point(x, y, 1'b0);
        collect(2, -1, -1);
        exp_frames++;
        d = frame_diffs();
        checks++; if (timed_out || d !== 0) begin errors++; $display("FAIL rst_new_frame diffs=%0d timeout=%b exp=0/0", d, timed_out); end
        checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL rst_new_frames got=%0d exp=%0d", frames_sent, exp_frames); end
    endtask

    task automatic test_back_to_back();
        int d;
        logic [COORD_W-1:0] x = rand_coord(), y = rand_coord();
        send_point(GX, GY, 1'b0);
        collect(0, -1, -1);
        exp_frames++;
        checks++; if (bus.tx_valid !== 1'b0 || bus.pt_ready !== 1'b1) begin errors++; $display("FAIL b2b_bubble tx_valid=%b pt_ready=%b exp=0/1", bus.tx_valid, bus.pt_ready); end
        build_expected(x, y, 1'b0);
        send_point(x, y, 1'b0);
        collect(0, -1, -1);
        exp_frames++;
        d = frame_diffs();
        checks++; if (d !== 0 || tcycles !== FLEN) begin errors++; $display("FAIL b2b_frame diffs=%0d cycles=%0d exp=0/%0d", d, tcycles, FLEN); end
        checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL b2b_frames got=%0d exp=%0d", frames_sent, exp_frames); end
    endtask

    task automatic test_random();
        int d;
        for (int f = 0; f < 8; f++) begin
            logic [COORD_W-1:0] x = rand_coord(), y = rand_coord();
            bit inf = ($urandom_range(0, 5) == 0);
            build_expected(x, y, inf);
            send_point(x, y, inf);
            collect(2, -1, -1);
            exp_frames++;
            d = frame_diffs();
            checks++; if (timed_out || d !== 0 || stall_bad !== 0) begin
                errors++; $display("FAIL rand_frame%0d diffs=%0d stall=%0d timeout=%b exp=0/0/0", f, d, stall_bad, timed_out);
            end
            checks++; if (frames_sent !== exp_frames) begin errors++; $display("FAIL rand_frames%0d got=%0d exp=%0d", f, frames_sent, exp_frames); end
        end
    endtask

    initial begin
        test_reset();
        test_generator();
        test_odd_y();
        test_infinity();
        test_stall();
        test_busy_ignore();
        test_final_collision();
        test_midframe_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
